// File: rtl/stack_engine.sv
// Byte-wide hardware stack on page 01: pushes and pulls 16-bit words as two
// sequential byte accesses, with optional +1 adjust on the pulled word.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting; sp_load or req accepted here
// PUSH_HI | write wdata[15:8] at {01,sp}, then decrement sp
// PUSH_LO | write wdata[7:0] at {01,sp}, then decrement sp
// POP_LO  | read low byte at {01,sp}, then increment sp
// POP_HI  | read high byte at {01,sp}, form rdata, sp held
// DONE    | one-cycle completion pulse
module stack_engine (
  input  logic        ph1,
  input  logic        reset,
  input  logic        req,
  input  logic        op,
  input  logic [15:0] wdata,
  input  logic        inc_on_pop,
  input  logic        sp_load,
  input  logic [7:0]  sp_in,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] rdata,
  output logic [7:0]  sp,
  output logic [15:0] mem_adr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we
);

  typedef enum logic [2:0] {
    IDLE,
    PUSH_HI,
    PUSH_LO,
    POP_LO,
    POP_HI,
    DONE
  } state_t;

  state_t      state;
  logic [15:0] wbuf;
  logic [7:0]  lo_byte;
  logic        inc_q;

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      sp      <= 8'hFF;
      wbuf    <= 16'h0000;
      lo_byte <= 8'h00;
      inc_q   <= 1'b0;
      rdata   <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          // sp_load wins over req in the same cycle
          if (sp_load) begin
            sp <= sp_in;
          end else if (req) begin
            if (!op) begin
              wbuf  <= wdata;
              state <= PUSH_HI;
            end else begin
              sp    <= sp + 8'd1;
              inc_q <= inc_on_pop;
              state <= POP_LO;
            end
          end
        end
        PUSH_HI: begin
          sp    <= sp - 8'd1;
          state <= PUSH_LO;
        end
        PUSH_LO: begin
          sp    <= sp - 8'd1;
          state <= DONE;
        end
        POP_LO: begin
          lo_byte <= mem_rdata;
          sp      <= sp + 8'd1;
          state   <= POP_HI;
        end
        POP_HI: begin
          // rdata updates only when a pull completes, so it holds between pulls
          rdata <= {mem_rdata, lo_byte} + {15'd0, inc_q};
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode from state only, so reset removes mem_we immediately
  assign busy    = (state == PUSH_HI) || (state == PUSH_LO) ||
                   (state == POP_LO)  || (state == POP_HI);
  assign done    = (state == DONE);
  assign mem_we  = (state == PUSH_HI) || (state == PUSH_LO);
  assign mem_adr = {8'h01, sp};

  always_comb begin
    mem_wdata = 8'h00;
    if (state == PUSH_HI)      mem_wdata = wbuf[15:8];
    else if (state == PUSH_LO) mem_wdata = wbuf[7:0];
  end

endmodule

// File: tb/tb_stack_engine.sv
// Scoreboard bench for stack_engine: stimulus queues expected writes and
// completions; a negedge monitor pops and compares as the DUT presents them.
module tb_stack_engine;

  logic        ph1;
  logic        reset;
  logic        req;
  logic        op;
  logic [15:0] wdata;
  logic        inc_on_pop;
  logic        sp_load;
  logic [7:0]  sp_in;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic        done;
  logic [15:0] rdata;
  logic [7:0]  sp;
  logic [15:0] mem_adr;
  logic [7:0]  mem_wdata;
  logic        mem_we;

  stack_engine dut (
    .ph1        (ph1),
    .reset      (reset),
    .req        (req),
    .op         (op),
    .wdata      (wdata),
    .inc_on_pop (inc_on_pop),
    .sp_load    (sp_load),
    .sp_in      (sp_in),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .done       (done),
    .rdata      (rdata),
    .sp         (sp),
    .mem_adr    (mem_adr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we)
  );

  typedef struct {
    logic [15:0] adr;
    logic [7:0]  data;
  } exp_wr_t;

  typedef struct {
    logic        pull;
    logic [15:0] rdata;
    logic [7:0]  sp;
  } exp_done_t;

  exp_wr_t   wq[$];
  exp_done_t dq[$];

  int errors = 0;
  int checks = 0;
  int busy_run = 0;
  logic prev_done = 1'b0;

  logic [7:0] mem [256];

  initial begin
    ph1 = 1'b0;
    forever #5 ph1 = ~ph1;
  end

  assign mem_rdata = mem[mem_adr[7:0]];

  always @(posedge ph1) begin
    if (mem_we) mem[mem_adr[7:0]] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge ph1) begin
    if (!reset) begin
      busy_run  = 0;
      prev_done = 1'b0;
    end else begin
      if (busy) busy_run++;
      if (mem_we) begin
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got %0h@%0h expected none", mem_wdata, mem_adr);
        end else begin
          exp_wr_t w;
          w = wq.pop_front();
          chk("wr_adr", mem_adr, w.adr);
          chk("wr_data", mem_wdata, w.data);
        end
      end
      if (done) begin
        chk("done_single_cycle", prev_done, 0);
        chk("busy_len", busy_run, 2);
        chk("busy_in_done", busy, 0);
        if (dq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected none");
        end else begin
          exp_done_t d;
          d = dq.pop_front();
          chk("done_sp", sp, d.sp);
          if (d.pull) chk("done_rdata", rdata, d.rdata);
        end
        busy_run = 0;
      end
      prev_done = done;
    end
  end

  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_done_seen"}, done, 1);
    tick();
  endtask

  task automatic do_push(input logic [15:0] w);
    req = 1'b1; op = 1'b0; wdata = w;
    tick();
    req = 1'b0;
    wait_done("push");
  endtask

  task automatic do_pull(input logic inc);
    req = 1'b1; op = 1'b1; inc_on_pop = inc;
    tick();
    req = 1'b0;
    wait_done("pull");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reset = 1'b0; req = 1'b0; op = 1'b0; wdata = 16'h0;
    inc_on_pop = 1'b0; sp_load = 1'b0; sp_in = 8'h00;
    repeat (2) @(posedge ph1);
    #1;
    chk("rst_sp", sp, 8'hFF);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_wdata", mem_wdata, 8'h00);
    chk("rst_adr", mem_adr, 16'h01FF);
    reset = 1'b1;

    wq.push_back('{16'h01FF, 8'h12});
    wq.push_back('{16'h01FE, 8'h34});
    dq.push_back('{1'b0, 16'h0000, 8'hFD});
    do_push(16'h1234);
    chk("push1_sp", sp, 8'hFD);

    dq.push_back('{1'b1, 16'h1235, 8'hFF});
    do_pull(1'b1);
    chk("pull1_sp", sp, 8'hFF);
    chk("pull1_rdata_held", rdata, 16'h1235);

    sp_load = 1'b1; sp_in = 8'h00;
    tick();
    sp_load = 1'b0;
    chk("load00_sp", sp, 8'h00);
    wq.push_back('{16'h0100, 8'hAB});
    wq.push_back('{16'h01FF, 8'hCD});
    dq.push_back('{1'b0, 16'h0000, 8'hFE});
    do_push(16'hABCD);
    dq.push_back('{1'b1, 16'hABCD, 8'h00});
    do_pull(1'b0);
    chk("wrap_sp", sp, 8'h00);

    sp_load = 1'b1; sp_in = 8'h80; req = 1'b1; op = 1'b0; wdata = 16'h5A5A;
    tick();
    chk("prio_sp", sp, 8'h80);
    chk("prio_busy", busy, 0);
    chk("prio_we", mem_we, 0);
    sp_load = 1'b0;
    wq.push_back('{16'h0180, 8'h5A});
    wq.push_back('{16'h017F, 8'h5A});
    dq.push_back('{1'b0, 16'h0000, 8'h7E});
    tick();
    req = 1'b0;
    chk("prio_accept_busy", busy, 1);
    wait_done("prio_push");

    wq.push_back('{16'h017E, 8'hFF});
    wq.push_back('{16'h017D, 8'hFF});
    dq.push_back('{1'b0, 16'h0000, 8'h7C});
    do_push(16'hFFFF);
    dq.push_back('{1'b1, 16'h0000, 8'h7E});
    do_pull(1'b1);
    chk("ffff_done_low_after", done, 0);
    chk("ffff_rdata_held", rdata, 16'h0000);

    reset = 1'b0;
    #2;
    chk("rst2_sp", sp, 8'hFF);
    reset = 1'b1;
    wq.push_back('{16'h01FF, 8'h55});
    req = 1'b1; op = 1'b0; wdata = 16'h5555;
    tick();
    req = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("abort_we", mem_we, 0);
    chk("abort_sp", sp, 8'hFF);
    chk("abort_busy", busy, 0);
    chk("abort_wdata", mem_wdata, 8'h00);
    repeat (3) tick();
    chk("abort_mem_ff", mem[8'hFF], 8'h55);
    chk("abort_mem_fe", mem[8'hFE], 8'h34);
    reset = 1'b1;
    repeat (3) tick();

    chk("wq_empty", wq.size(), 0);
    chk("dq_empty", dq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
